seg7_scan_driver: RTL

- Sequential stage directly upstream of the 4-bit-to-7-segment decoder on the lab board.
- Holds a multi-digit display value and time-multiplexes it across DIGITS common-anode digits.
- Each scan slot presents one 4-bit nibble on digit_sel, which feeds the decoder's select input, and drives the matching active-low anode.
- New values are double-buffered and committed only at frame boundaries, so a partly updated number is never displayed.

---
 rtl/seg7_pkg.sv | 29 ++
 rtl/seg7_prescaler.sv | 28 ++
 rtl/seg7_scan_driver.sv | 108 ++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scan driver.
package seg7_pkg;

    localparam int DIGITS_DEF   = 4;
    localparam int SCAN_DIV_DEF = 50000;
    localparam int MAX_DIGITS   = 8;

    // Common-anode digits are lit by a low anode, so all ones means dark.
    localparam logic [MAX_DIGITS-1:0] AN_OFF = {MAX_DIGITS{1'b1}};

    // Bit i set when digit i (i > 0) and every digit above it hold zero.
    function automatic logic [MAX_DIGITS-1:0] lz_blank_vec(
        input logic [4*MAX_DIGITS-1:0] word,
        input int                      digits
    );
        logic [MAX_DIGITS-1:0] vec;
        logic                  zero_run;
        vec      = '0;
        zero_run = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (i < digits) begin
                zero_run = zero_run & (word[4*i +: 4] == 4'h0);
                vec[i]   = zero_run;
            end
        end
        return vec;
    endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// Free-running divider: tick is high for one cycle out of every SCAN_DIV.
module seg7_prescaler #(
    parameter int SCAN_DIV = 50000,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = (cnt_q == CNT_W'(SCAN_DIV - 1));

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Double-buffered, time-multiplexed digit scanner feeding a 4-bit seven-segment decoder.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS   = DIGITS_DEF,
    parameter int SCAN_DIV = SCAN_DIV_DEF,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic                  load,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic                  lzb_en,
    output logic [3:0]            digit_sel,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done,
    output logic                  pending
);

    localparam int IDX_W = $clog2(DIGITS);

    logic                  tick;
    logic                  wrap;

    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*DIGITS-1:0]   disp_q, disp_d;
    logic [4*DIGITS-1:0]   pend_q, pend_d;
    logic                  pending_q, pending_d;
    logic                  frame_done_q;
    logic [3:0]            digit_sel_q, digit_sel_d;
    logic [DIGITS-1:0]     an_q, an_d;

    logic [MAX_DIGITS-1:0] lz_all;
    logic [DIGITS-1:0]     blank;

    seg7_prescaler #(
        .SCAN_DIV (SCAN_DIV),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick)
    );

    assign wrap = tick && (idx_q == IDX_W'(DIGITS - 1));

    always_comb begin
        idx_d = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end
    end

    // A load coinciding with the wrap goes straight to the display so it is never held a frame.
    always_comb begin
        disp_d    = disp_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        if (wrap) begin
            pending_d = 1'b0;
            if (load) begin
                disp_d = value_in;
            end else if (pending_q) begin
                disp_d = pend_q;
            end
        end else if (load) begin
            pend_d    = value_in;
            pending_d = 1'b1;
        end
    end

    always_comb begin
        lz_all = lz_blank_vec(32'(disp_q), DIGITS);
        blank  = blank_mask | (lzb_en ? lz_all[DIGITS-1:0] : '0);
    end

    always_comb begin
        digit_sel_d = disp_q[4*idx_q +: 4];
        an_d        = blank[idx_q] ? AN_OFF[DIGITS-1:0] : ~(DIGITS'(1) << idx_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            digit_sel_q  <= 4'h0;
            an_q         <= AN_OFF[DIGITS-1:0];
        end else begin
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pending_q    <= pending_d;
            frame_done_q <= wrap;
            digit_sel_q  <= digit_sel_d;
            an_q         <= an_d;
        end
    end

    assign digit_sel  = digit_sel_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;
    assign pending    = pending_q;

endmodule
